// File: rtl/alu_share_pkg.sv
// Shared constants, FSM state encoding and mult-detect helper for the ALU sharing controller.
package alu_share_pkg;

   localparam logic [1:0] OP_RTYPE  = 2'b00;
   localparam logic [1:0] OP_BRANCH = 2'b01;
   localparam logic [1:0] OP_MEM    = 2'b10;

   localparam logic [3:0] FN_ADD  = 4'b0000;
   localparam logic [3:0] FN_SUB  = 4'b0001;
   localparam logic [3:0] FN_MULT = 4'b0010;
   localparam logic [3:0] FN_AND  = 4'b0011;
   localparam logic [3:0] FN_OR   = 4'b0100;
   localparam logic [3:0] FN_XOR  = 4'b0101;
   localparam logic [3:0] FN_INV  = 4'b0110;

   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t EXEC = 2'd1;
   localparam state_t RESP = 2'd2;

   // Only an R-type mult is multi-cycle; branch/mem classes ignore the function code.
   function automatic logic is_mult(input logic [1:0] op, input logic [3:0] code);
      return {op, code} == {OP_RTYPE, FN_MULT};
   endfunction

endpackage

// File: rtl/alu_share_arb2.sv
// Two-input grant generator: fixed priority (requester 0 wins) by default,
// round-robin with a 1-bit favoured pointer when ALU_SHARE_RR_EN is defined.
module arb2 (
`ifdef ALU_SHARE_RR_EN
   input  logic       clk,
   input  logic       rst,
   input  logic       adv,
`endif
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       gnt_id
);

`ifdef ALU_SHARE_RR_EN
   logic ptr;

   // After a grant the pointer favours the requester that lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)      ptr <= 1'b0;
      else if (adv) ptr <= ~gnt_id;
   end

   // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
   always_comb begin
      gnt_id = 1'b0;
      if (req == 2'b11) gnt_id = ptr;
      else              gnt_id = req[1];
   end
`else
   always_comb begin
      gnt_id = 1'b0;
      if (!req[0]) gnt_id = req[1];
   end
`endif

   assign gnt = {req[1] & gnt_id, req[0] & ~gnt_id};

endmodule

// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one ALU, holds the ALU buses for the op latency and
// returns the captured result on a tagged valid/ready channel. Option: ALU_SHARE_RR_EN.
module alu_share_ctrl
   import alu_share_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MULT_LAT = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             REQ0_VALID,
   output logic             REQ0_READY,
   input  logic [1:0]       REQ0_ALU_OP,
   input  logic [3:0]       REQ0_OP_CODE,
   input  logic [WIDTH-1:0] REQ0_A,
   input  logic [WIDTH-1:0] REQ0_B,
   input  logic             REQ1_VALID,
   output logic             REQ1_READY,
   input  logic [1:0]       REQ1_ALU_OP,
   input  logic [3:0]       REQ1_OP_CODE,
   input  logic [WIDTH-1:0] REQ1_A,
   input  logic [WIDTH-1:0] REQ1_B,
   output logic [1:0]       ALU_OP,
   output logic [3:0]       ALU_OP_CODE,
   output logic [WIDTH-1:0] ALU_A,
   output logic [WIDTH-1:0] ALU_B,
   input  logic [WIDTH-1:0] ALU_RESULT,
   output logic             RSP_VALID,
   input  logic             RSP_READY,
   output logic             RSP_ID,
   output logic [WIDTH-1:0] RSP_RESULT,
   output logic             BUSY
);

   localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);

   state_t           state;
   logic [3:0]       cnt;
   logic             id_q;
   logic [1:0]       req;
   logic [1:0]       gnt;
   logic             gnt_id;
   logic             accept;
   logic [1:0]       sel_op;
   logic [3:0]       sel_code;
   logic [WIDTH-1:0] sel_a;
   logic [WIDTH-1:0] sel_b;

   assign req    = {REQ1_VALID, REQ0_VALID};
   assign accept = (state == IDLE) && (req != 2'b00);

   arb2 u_arb (
`ifdef ALU_SHARE_RR_EN
      .clk    (CLK),
      .rst    (RESET),
      .adv    (accept),
`endif
      .req    (req),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign REQ0_READY = (state == IDLE) & gnt[0];
   assign REQ1_READY = (state == IDLE) & gnt[1];

   assign sel_op   = gnt_id ? REQ1_ALU_OP  : REQ0_ALU_OP;
   assign sel_code = gnt_id ? REQ1_OP_CODE : REQ0_OP_CODE;
   assign sel_a    = gnt_id ? REQ1_A       : REQ0_A;
   assign sel_b    = gnt_id ? REQ1_B       : REQ0_B;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state       <= IDLE;
         cnt         <= 4'd0;
         id_q        <= 1'b0;
         ALU_OP      <= 2'b00;
         ALU_OP_CODE <= 4'b0000;
         ALU_A       <= '0;
         ALU_B       <= '0;
         RSP_RESULT  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  ALU_OP      <= sel_op;
                  ALU_OP_CODE <= sel_code;
                  ALU_A       <= sel_a;
                  ALU_B       <= sel_b;
                  id_q        <= gnt_id;
                  cnt         <= is_mult(sel_op, sel_code) ? MULT_CNT : 4'd1;
                  state       <= EXEC;
               end
            end
            EXEC: begin
               // ALU buses stay untouched here so the ALU sees stable inputs for the whole op.
               if (cnt == 4'd1) begin
                  RSP_RESULT <= ALU_RESULT;
                  state      <= RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (RSP_READY) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign RSP_VALID = (state == RESP);
   assign RSP_ID    = id_q;
   assign BUSY      = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU and a response scoreboard queue.
module tb_alu_share_ctrl;
   import alu_share_pkg::*;

   localparam int WIDTH    = 32;
   localparam int MULT_LAT = 4;

   logic             CLK;
   logic             RESET;
   logic             REQ0_VALID, REQ0_READY;
   logic [1:0]       REQ0_ALU_OP;
   logic [3:0]       REQ0_OP_CODE;
   logic [WIDTH-1:0] REQ0_A, REQ0_B;
   logic             REQ1_VALID, REQ1_READY;
   logic [1:0]       REQ1_ALU_OP;
   logic [3:0]       REQ1_OP_CODE;
   logic [WIDTH-1:0] REQ1_A, REQ1_B;
   logic [1:0]       ALU_OP;
   logic [3:0]       ALU_OP_CODE;
   logic [WIDTH-1:0] ALU_A, ALU_B, ALU_RESULT;
   logic             RSP_VALID, RSP_READY, RSP_ID;
   logic [WIDTH-1:0] RSP_RESULT;
   logic             BUSY;

   alu_share_ctrl #(.WIDTH(WIDTH), .MULT_LAT(MULT_LAT)) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_ALU_OP(REQ0_ALU_OP),
      .REQ0_OP_CODE(REQ0_OP_CODE), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B),
      .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_ALU_OP(REQ1_ALU_OP),
      .REQ1_OP_CODE(REQ1_OP_CODE), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
      .ALU_OP(ALU_OP), .ALU_OP_CODE(ALU_OP_CODE), .ALU_A(ALU_A), .ALU_B(ALU_B),
      .ALU_RESULT(ALU_RESULT),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
      .RSP_RESULT(RSP_RESULT), .BUSY(BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [WIDTH-1:0] alu_model(input logic [1:0] op, input logic [3:0] code,
                                                  input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] r;
      r = '0;
      if (op == OP_BRANCH)   r = a - b;
      else if (op == OP_MEM) r = a + b;
      else if (op == OP_RTYPE) begin
         case (code)
            FN_ADD:  r = a + b;
            FN_SUB:  r = a - b;
            FN_MULT: r = a * b;
            FN_AND:  r = a & b;
            FN_OR:   r = a | b;
            FN_XOR:  r = a ^ b;
            FN_INV:  r = ~a;
            default: r = '0;
         endcase
      end
      return r;
   endfunction

   always_comb ALU_RESULT = alu_model(ALU_OP, ALU_OP_CODE, ALU_A, ALU_B);

   typedef struct packed {
      logic             id;
      logic [WIDTH-1:0] result;
   } rsp_t;

   rsp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_rsp = 0;

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every completed handshake pops the oldest expected response.
   always @(negedge CLK) begin
      if (!RESET && RSP_VALID && RSP_READY) begin
         rsp_t e;
         n_rsp++;
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL rsp_unexpected: observed id %0d result %0h with nothing expected", RSP_ID, RSP_RESULT);
         end else begin
            e = exp_q.pop_front();
            check("rsp_id", {31'b0, RSP_ID}, {31'b0, e.id});
            check("rsp_result", RSP_RESULT, e.result);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic drive_req(input int r, input logic [1:0] op, input logic [3:0] code,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (r == 0) begin
         REQ0_VALID = 1'b1; REQ0_ALU_OP = op; REQ0_OP_CODE = code; REQ0_A = a; REQ0_B = b;
      end else begin
         REQ1_VALID = 1'b1; REQ1_ALU_OP = op; REQ1_OP_CODE = code; REQ1_A = a; REQ1_B = b;
      end
   endtask

   // Called one step after accept; checks the ALU buses every EXEC cycle and returns accept-to-valid cycles.
   task automatic wait_rsp(input logic [1:0] op, input logic [3:0] code, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, output int n);
      n = 1;
      while (!RSP_VALID && n < 40) begin
         check("exec_alu_op", {30'b0, ALU_OP}, {30'b0, op});
         check("exec_alu_code", {28'b0, ALU_OP_CODE}, {28'b0, code});
         check("exec_alu_a", ALU_A, a);
         check("exec_alu_b", ALU_B, b);
         step();
         n++;
      end
   endtask

   task automatic back_to_idle();
      step();
      check("idle_busy", {31'b0, BUSY}, 32'd0);
   endtask

   initial begin
      int         n;
      int         c0, c1, k, guard;
      logic [7:0] exp_order;

      RESET = 1'b1; RSP_READY = 1'b0;
      REQ0_VALID = 1'b0; REQ0_ALU_OP = 2'b00; REQ0_OP_CODE = 4'b0; REQ0_A = '0; REQ0_B = '0;
      REQ1_VALID = 1'b0; REQ1_ALU_OP = 2'b00; REQ1_OP_CODE = 4'b0; REQ1_A = '0; REQ1_B = '0;
`ifdef ALU_SHARE_RR_EN
      exp_order = 8'b1010_1010;
`else
      exp_order = 8'b1111_0000;
`endif

      // Reset state
      step(); step();
      check("rst_ready0", {31'b0, REQ0_READY}, 32'd0);
      check("rst_ready1", {31'b0, REQ1_READY}, 32'd0);
      check("rst_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
      check("rst_rsp_id", {31'b0, RSP_ID}, 32'd0);
      check("rst_rsp_result", RSP_RESULT, 32'd0);
      check("rst_alu_op", {30'b0, ALU_OP}, 32'd0);
      check("rst_alu_code", {28'b0, ALU_OP_CODE}, 32'd0);
      check("rst_alu_a", ALU_A, 32'd0);
      check("rst_alu_b", ALU_B, 32'd0);
      check("rst_busy", {31'b0, BUSY}, 32'd0);
      RESET = 1'b0;
      step();

      // Single-cycle add from requester 0
      RSP_READY = 1'b1;
      drive_req(0, OP_RTYPE, FN_ADD, 32'd5, 32'd7);
      #1;
      check("t1_ready0", {31'b0, REQ0_READY}, 32'd1);
      check("t1_ready1", {31'b0, REQ1_READY}, 32'd0);
      exp_q.push_back(rsp_t'{1'b0, 32'd12});
      step();
      REQ0_VALID = 1'b0;
      #1;
      check("t1_ready0_once", {31'b0, REQ0_READY}, 32'd0);
      check("t1_busy", {31'b0, BUSY}, 32'd1);
      wait_rsp(OP_RTYPE, FN_ADD, 32'd5, 32'd7, n);
      check("t1_latency", n, 32'd2);
      back_to_idle();

      // Mult from requester 1: buses held MULT_LAT cycles
      drive_req(1, OP_RTYPE, FN_MULT, 32'd6, 32'd9);
      #1;
      check("t2_ready1", {31'b0, REQ1_READY}, 32'd1);
      exp_q.push_back(rsp_t'{1'b1, 32'd54});
      step();
      REQ1_VALID = 1'b0;
      wait_rsp(OP_RTYPE, FN_MULT, 32'd6, 32'd9, n);
      check("t2_latency", n, 32'(MULT_LAT + 1));
      back_to_idle();

      // Mem class carrying the mult function code stays single-cycle
      drive_req(0, OP_MEM, FN_MULT, 32'd100, 32'd23);
      #1;
      check("t3_ready0", {31'b0, REQ0_READY}, 32'd1);
      exp_q.push_back(rsp_t'{1'b0, 32'd123});
      step();
      REQ0_VALID = 1'b0;
      wait_rsp(OP_MEM, FN_MULT, 32'd100, 32'd23, n);
      check("t3_latency", n, 32'd2);
      back_to_idle();

      // Branch class with the mult code, from requester 1
      drive_req(1, OP_BRANCH, FN_MULT, 32'd50, 32'd8);
      #1;
      check("t3b_ready1", {31'b0, REQ1_READY}, 32'd1);
      exp_q.push_back(rsp_t'{1'b1, 32'd42});
      step();
      REQ1_VALID = 1'b0;
      wait_rsp(OP_BRANCH, FN_MULT, 32'd50, 32'd8, n);
      check("t3b_latency", n, 32'd2);
      back_to_idle();

      // Contention: four ops from each requester
      c0 = 0; c1 = 0; k = 0; guard = 0;
      while ((c0 < 4 || c1 < 4) && guard < 200) begin
         REQ0_VALID = (c0 < 4); REQ0_ALU_OP = OP_RTYPE; REQ0_OP_CODE = FN_ADD;
         REQ0_A = 32'(10 + c0); REQ0_B = 32'(c0);
         REQ1_VALID = (c1 < 4); REQ1_ALU_OP = OP_RTYPE; REQ1_OP_CODE = FN_SUB;
         REQ1_A = 32'd1000; REQ1_B = 32'(3 * c1);
         #1;
         if (REQ0_READY || REQ1_READY) begin
            check("cont_onehot", {31'b0, REQ0_READY & REQ1_READY}, 32'd0);
            check("cont_order", {31'b0, REQ1_READY}, {31'b0, exp_order[k]});
            if (REQ1_READY) begin
               exp_q.push_back(rsp_t'{1'b1, 32'(1000 - 3 * c1)});
               c1++;
            end else begin
               exp_q.push_back(rsp_t'{1'b0, 32'(10 + 2 * c0)});
               c0++;
            end
            k++;
         end
         step();
         guard++;
      end
      REQ0_VALID = 1'b0; REQ1_VALID = 1'b0;
      check("cont_done", {31'b0, guard < 200}, 32'd1);
      guard = 0;
      while ((exp_q.size() != 0 || BUSY) && guard < 50) begin
         step();
         guard++;
      end
      check("cont_drained", 32'(exp_q.size()), 32'd0);

      // Back-pressure: RSP_READY low for 10 cycles in RESP
      RSP_READY = 1'b0;
      drive_req(0, OP_RTYPE, FN_XOR, 32'hF0F0_1234, 32'h0F0F_0000);
      #1;
      check("t5_ready0", {31'b0, REQ0_READY}, 32'd1);
      exp_q.push_back(rsp_t'{1'b0, 32'hFFFF_1234});
      step();
      REQ0_VALID = 1'b0;
      drive_req(1, OP_MEM, FN_ADD, 32'd40, 32'd2);
      wait_rsp(OP_RTYPE, FN_XOR, 32'hF0F0_1234, 32'h0F0F_0000, n);
      check("t5_latency", n, 32'd2);
      for (int i = 0; i < 10; i++) begin
         check("bp_rsp_valid", {31'b0, RSP_VALID}, 32'd1);
         check("bp_rsp_result", RSP_RESULT, 32'hFFFF_1234);
         check("bp_rsp_id", {31'b0, RSP_ID}, 32'd0);
         check("bp_ready0", {31'b0, REQ0_READY}, 32'd0);
         check("bp_ready1", {31'b0, REQ1_READY}, 32'd0);
         check("bp_busy", {31'b0, BUSY}, 32'd1);
         step();
      end
      RSP_READY = 1'b1;
      #1;
      check("bp_no_grant_in_handshake", {31'b0, REQ1_READY}, 32'd0);
      step();
      check("bp_idle_busy", {31'b0, BUSY}, 32'd0);
      check("bp_idle_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
      check("bp_next_ready1", {31'b0, REQ1_READY}, 32'd1);
      exp_q.push_back(rsp_t'{1'b1, 32'd42});
      step();
      REQ1_VALID = 1'b0;
      wait_rsp(OP_MEM, FN_ADD, 32'd40, 32'd2, n);
      check("t5b_latency", n, 32'd2);
      back_to_idle();

      // Reset during the second EXEC cycle of a mult drops the op
      drive_req(1, OP_RTYPE, FN_MULT, 32'd7, 32'd8);
      #1;
      check("t6_ready1", {31'b0, REQ1_READY}, 32'd1);
      step();
      REQ1_VALID = 1'b0;
      step();
      RESET = 1'b1;
      #1;
      check("mid_rst_busy", {31'b0, BUSY}, 32'd0);
      check("mid_rst_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
      check("mid_rst_rsp_id", {31'b0, RSP_ID}, 32'd0);
      check("mid_rst_rsp_result", RSP_RESULT, 32'd0);
      check("mid_rst_alu_op", {30'b0, ALU_OP}, 32'd0);
      check("mid_rst_alu_code", {28'b0, ALU_OP_CODE}, 32'd0);
      check("mid_rst_alu_a", ALU_A, 32'd0);
      check("mid_rst_alu_b", ALU_B, 32'd0);
      step();
      RESET = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         check("post_rst_no_rsp", {31'b0, RSP_VALID}, 32'd0);
      end

      // Both requesters after reset: requester 0 is favoured first in either mode
      drive_req(0, OP_RTYPE, FN_AND, 32'h0000_FF00, 32'h0000_0FF0);
      drive_req(1, OP_RTYPE, FN_OR, 32'h0000_00F0, 32'h0000_0F00);
      #1;
      check("t7_ready0", {31'b0, REQ0_READY}, 32'd1);
      check("t7_ready1", {31'b0, REQ1_READY}, 32'd0);
      exp_q.push_back(rsp_t'{1'b0, 32'h0000_0F00});
      step();
      REQ0_VALID = 1'b0;
      wait_rsp(OP_RTYPE, FN_AND, 32'h0000_FF00, 32'h0000_0FF0, n);
      check("t7_latency", n, 32'd2);
      back_to_idle();
      #1;
      check("t7_ready1_next", {31'b0, REQ1_READY}, 32'd1);
      exp_q.push_back(rsp_t'{1'b1, 32'h0000_0FF0});
      step();
      REQ1_VALID = 1'b0;
      wait_rsp(OP_RTYPE, FN_OR, 32'h0000_00F0, 32'h0000_0F00, n);
      check("t7b_latency", n, 32'd2);
      back_to_idle();

      step();
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);
      check("final_rsp_count", n_rsp, 32'd16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
